// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write scheduler.
package regfile_pkg;

    localparam int unsigned DATA_W  = 20;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned NREGS   = 16;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_pending_counter.sv
// Saturating count of outstanding writes to one register.
module regfile_pending_counter
    import regfile_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic full,
    output logic underflow
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A reserve and a commit in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero   = (cnt_q != '0);
    assign full      = (cnt_q == MAX);
    assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter for the register-file write port plus a
// per-register scoreboard of outstanding writes.
module regfile_write_scheduler
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] rf_write,
    output logic [ADDR_W-1:0] rf_w_select,
    output logic              rf_w,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic [ADDR_W-1:0] chk1_addr,
    input  logic [ADDR_W-1:0] chk2_addr,
    output logic              chk1_busy,
    output logic              chk2_busy,
    output logic [NREGS-1:0]  pending,
    output logic              err
);

    req_id_e    last_grant_q;
    req_id_e    last_grant_d;
    logic       rf_w_q;
    logic       rf_w_d;
    wr_req_t    wr_q;
    wr_req_t    wr_d;
    logic       err_q;
    logic       err_d;
    logic       gnt0;
    logic       gnt1;

    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] nonzero;
    logic [NREGS-1:0] full;
    logic [NREGS-1:0] underflow;

    // Arbitration: on contention the requester not granted last time wins.
    always_comb begin
        gnt0         = req0_valid && (!req1_valid || (last_grant_q == REQ_LOAD));
        gnt1         = req1_valid && (!req0_valid || (last_grant_q == REQ_ALU));
        last_grant_d = last_grant_q;
        rf_w_d       = gnt0 || gnt1;
        wr_d         = wr_q;
        err_d        = err_q || (|underflow);
        if (gnt0) begin
            last_grant_d = REQ_ALU;
            wr_d         = '{addr: req0_addr, data: req0_data};
        end else if (gnt1) begin
            last_grant_d = REQ_LOAD;
            wr_d         = '{addr: req1_addr, data: req1_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_LOAD;
            rf_w_q       <= 1'b0;
            wr_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_w_q       <= rf_w_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
        end
    end

    // Reservation increments, port commit decrements.
    for (genvar i = 0; i < NREGS; i++) begin : g_cnt
        assign inc[i] = rsv_valid && rsv_ready && (rsv_addr == ADDR_W'(i));
        assign dec[i] = rf_w_q && (wr_q.addr == ADDR_W'(i));

        regfile_pending_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[i]),
            .dec       (dec[i]),
            .nonzero   (nonzero[i]),
            .full      (full[i]),
            .underflow (underflow[i])
        );
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign rf_w        = rf_w_q;
    assign rf_write    = wr_q.data;
    assign rf_w_select = wr_q.addr;
    assign rsv_ready   = !full[rsv_addr];
    assign chk1_busy   = nonzero[chk1_addr];
    assign chk2_busy   = nonzero[chk2_addr];
    assign pending     = nonzero;
    assign err         = err_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized bench for regfile_write_scheduler with a behavioural model and directed literal checks.
module tb_regfile_write_scheduler;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic [DATA_W-1:0] rf_write;
    logic [ADDR_W-1:0] rf_w_select;
    logic              rf_w;
    logic              rsv_valid = 1'b0;
    logic [ADDR_W-1:0] rsv_addr = '0;
    logic              rsv_ready;
    logic [ADDR_W-1:0] chk1_addr = '0;
    logic [ADDR_W-1:0] chk2_addr = '0;
    logic              chk1_busy;
    logic              chk2_busy;
    logic [NREGS-1:0]  pending;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    regfile_write_scheduler dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_write(rf_write), .rf_w_select(rf_w_select), .rf_w(rf_w),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .chk1_addr(chk1_addr), .chk2_addr(chk2_addr), .chk1_busy(chk1_busy), .chk2_busy(chk2_busy),
        .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model: counts per register, sticky error, one-deep write pipe.
    int                m_cnt [NREGS];
    logic              m_rfw = 1'b0;
    logic [ADDR_W-1:0] m_wsel = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic              m_err = 1'b0;
    logic              m_last = 1'b1;
    logic              m_g0;
    logic              m_g1;
    logic              m_rsv_ok;

    assign m_g0     = req0_valid && (!req1_valid || m_last == 1'b1);
    assign m_g1     = req1_valid && (!req0_valid || m_last == 1'b0);
    assign m_rsv_ok = (m_cnt[rsv_addr] < CNT_MAX);

    initial for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_rfw   <= 1'b0;
            m_wsel  <= '0;
            m_wdata <= '0;
            m_err   <= 1'b0;
            m_last  <= 1'b1;
            for (int r = 0; r < NREGS; r++) m_cnt[r] <= 0;
        end else begin
            m_rfw <= m_g0 || m_g1;
            if (m_g0) begin
                m_wsel <= req0_addr; m_wdata <= req0_data; m_last <= 1'b0;
            end else if (m_g1) begin
                m_wsel <= req1_addr; m_wdata <= req1_data; m_last <= 1'b1;
            end
            for (int r = 0; r < NREGS; r++) begin
                if ((rsv_valid && m_rsv_ok && rsv_addr == r) && !(m_rfw && m_wsel == r))
                    m_cnt[r] <= m_cnt[r] + 1;
                else if (!(rsv_valid && m_rsv_ok && rsv_addr == r) && m_rfw && m_wsel == r && m_cnt[r] > 0)
                    m_cnt[r] <= m_cnt[r] - 1;
            end
            if (m_rfw && m_cnt[m_wsel] == 0) m_err <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NREGS-1:0] mp;
            for (int r = 0; r < NREGS; r++) mp[r] = (m_cnt[r] != 0);
            chk("m_req0_ready", 32'(req0_ready), 32'(m_g0));
            chk("m_req1_ready", 32'(req1_ready), 32'(m_g1));
            chk("m_rsv_ready",  32'(rsv_ready),  32'(m_rsv_ok));
            chk("m_chk1_busy",  32'(chk1_busy),  32'(m_cnt[chk1_addr] != 0));
            chk("m_chk2_busy",  32'(chk2_busy),  32'(m_cnt[chk2_addr] != 0));
            chk("m_pending",    32'(pending),    32'(mp));
            chk("m_err",        32'(err),        32'(m_err));
            chk("m_rf_w",       32'(rf_w),       32'(m_rfw));
            chk("m_rf_w_select",32'(rf_w_select),32'(m_wsel));
            chk("m_rf_write",   32'(rf_write),   32'(m_wdata));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic h0;
        logic h1;
        do_reset();
        cmp_en = 1'b1;

        // Reset state and first contention.
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 20'h12345;
        req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 20'h0ABCD;
        @(negedge clk);
        chk("t1_req0_ready", 32'(req0_ready), 1);
        chk("t1_req1_ready", 32'(req1_ready), 0);
        chk("rst_rf_w", 32'(rf_w), 0);
        chk("rst_sel", 32'(rf_w_select), 0);
        chk("rst_data", 32'(rf_write), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_err", 32'(err), 0);
        cyc(); req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_rf_w_a", 32'(rf_w), 1);
        chk("t1_sel_a", 32'(rf_w_select), 3);
        chk("t1_data_a", 32'(rf_write), 32'h12345);
        chk("t1_req1_ready_b", 32'(req1_ready), 1);
        cyc(); req1_valid = 1'b0;
        @(negedge clk);
        chk("t1_sel_b", 32'(rf_w_select), 5);
        chk("t1_data_b", 32'(rf_write), 32'h0ABCD);

        // Sustained contention alternates grants.
        do_reset();
        req0_addr = 4'hA; req0_data = 20'h0000A;
        req1_addr = 4'hB; req1_data = 20'h0000B;
        for (int k = 0; k < 8; k++) begin
            req0_valid = (k < 6);
            req1_valid = (k < 6);
            @(negedge clk);
            chk("t2_req0_ready", 32'(req0_ready), 32'((k < 6) && (k % 2 == 0)));
            chk("t2_req1_ready", 32'(req1_ready), 32'((k < 6) && (k % 2 == 1)));
            chk("t2_rf_w", 32'(rf_w), 32'((k >= 1) && (k <= 6)));
            if (k >= 1 && k <= 6) chk("t2_sel", 32'(rf_w_select), (k % 2 == 1) ? 32'hA : 32'hB);
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Saturation of r7 and busy through three commits.
        do_reset();
        chk1_addr = 4'd7; rsv_addr = 4'd7; rsv_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_rsv_ready", 32'(rsv_ready), 32'(k < 3));
            if (k == 3) begin
                chk("t3_pending7", 32'(pending[7]), 1);
                chk("t3_busy_full", 32'(chk1_busy), 1);
            end
            cyc();
        end
        rsv_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 20'h00777;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_busy", 32'(chk1_busy), 32'(k < 4));
            cyc();
            if (k == 2) req0_valid = 1'b0;
        end

        // Reserve and commit r9 together at count 1.
        do_reset();
        chk2_addr = 4'd9; rsv_addr = 4'd9; rsv_valid = 1'b1;
        cyc();
        rsv_valid = 1'b0; req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 20'h00999;
        cyc();
        req0_valid = 1'b0; rsv_valid = 1'b1;
        @(negedge clk);
        chk("t4_rf_w", 32'(rf_w), 1);
        chk("t4_sel", 32'(rf_w_select), 9);
        cyc();
        rsv_valid = 1'b0;
        @(negedge clk);
        chk("t4_busy", 32'(chk2_busy), 1);
        chk("t4_pending9", 32'(pending[9]), 1);
        chk("t4_err", 32'(err), 0);
        cyc();

        // Commit to r2 without reservation sets sticky err.
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 20'h00222;
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("t5_rf_w", 32'(rf_w), 1);
        cyc();
        @(negedge clk);
        chk("t5_err", 32'(err), 1);
        chk("t5_pending2", 32'(pending[2]), 0);
        repeat (3) cyc();
        @(negedge clk);
        chk("t5_err_sticky", 32'(err), 1);

        // Reset while a write sits on the output stage.
        rsv_valid = 1'b1; rsv_addr = 4'd4;
        cyc();
        rsv_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 20'h00111;
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t6_rf_w_before", 32'(rf_w), 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd6; req0_data = 20'h00666;
        req1_valid = 1'b1; req1_addr = 4'd8; req1_data = 20'h00888;
        @(negedge clk);
        chk("t6_rf_w", 32'(rf_w), 0);
        chk("t6_pending", 32'(pending), 0);
        chk("t6_err", 32'(err), 0);
        chk("t6_req0_ready", 32'(req0_ready), 1);
        chk("t6_req1_ready", 32'(req1_ready), 0);
        cyc(); req0_valid = 1'b0;
        cyc(); req1_valid = 1'b0;

        // Random traffic; requesters hold until accepted.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            cyc();
            reset = ($urandom_range(0, 299) == 0);
            if (!req0_valid || h0) begin
                req0_valid = ($urandom_range(0, 1) == 1);
                req0_addr  = ADDR_W'($urandom_range(0, 3));
                req0_data  = DATA_W'($urandom);
            end
            if (!req1_valid || h1) begin
                req1_valid = ($urandom_range(0, 1) == 1);
                req1_addr  = ADDR_W'($urandom_range(0, 3));
                req1_data  = DATA_W'($urandom);
            end
            rsv_valid = ($urandom_range(0, 2) != 0);
            rsv_addr  = ADDR_W'($urandom_range(0, 3));
            chk1_addr = ADDR_W'($urandom_range(0, 4));
            chk2_addr = ADDR_W'($urandom_range(0, 4));
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsv_valid = 1'b0;
        reset = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
